bf_pair_sched: RTL

Feed-side pairing scheduler for one FFT butterfly stage. It accepts a stream of 16-lane complex vectors, buffers the first DELAY_LENGTH vectors of each block, then pairs each of the next DELAY_LENGTH incoming vectors with its stored counterpart. It emits each pair as (a = stored, b = incoming) to the butterfly ALU. It consumes the delay-line write/read protocol from the reading side and sits between the previous stage output and the BF_ALU butterfly inputs.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/bf_vec_store.sv | 43 ++++
 rtl/bf_pair_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: types and constants shared by the FFT feed-side blocks.
//   LANES      : complex lanes per vector
//   CPLX_W     : default signed component width
//   cplx_vec_t : one 16-lane complex vector (real lanes, imag lanes)
//   pair_state_e : pairing scheduler state (FILL buffers, PAIR emits)
//   cnt_w()    : width of an index over d entries, at least 1 bit
package fft_pkg;

    localparam int LANES  = 16;
    localparam int CPLX_W = 9;

    typedef struct packed {
        logic [LANES-1:0][CPLX_W-1:0] re;
        logic [LANES-1:0][CPLX_W-1:0] im;
    } cplx_vec_t;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } pair_state_e;

    function automatic int cnt_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/bf_vec_store.sv
// bf_vec_store: DEPTH-entry register file of 16-lane complex vectors.
//   clk, rstn          : clock, async active-low reset (contents cleared)
//   we_i, waddr_i      : write strobe and slot index
//   wre_i, wim_i       : vector written into slot waddr_i
//   raddr_i            : read slot index
//   rre_o, rim_o       : combinational read of slot raddr_i
module bf_vec_store
    import fft_pkg::*;
#(
    parameter int WIDTH = CPLX_W,
    parameter int DEPTH = 16,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          we_i,
    input  logic [AW-1:0]                 waddr_i,
    input  logic [LANES-1:0][WIDTH-1:0]   wre_i,
    input  logic [LANES-1:0][WIDTH-1:0]   wim_i,
    input  logic [AW-1:0]                 raddr_i,
    output logic [LANES-1:0][WIDTH-1:0]   rre_o,
    output logic [LANES-1:0][WIDTH-1:0]   rim_o
);

    logic [LANES-1:0][WIDTH-1:0] re_q [DEPTH];
    logic [LANES-1:0][WIDTH-1:0] im_q [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (we_i) begin
            re_q[waddr_i] <= wre_i;
            im_q[waddr_i] <= wim_i;
        end
    end

    assign rre_o = re_q[raddr_i];
    assign rim_o = im_q[raddr_i];

endmodule

// File: rtl/bf_pair_sched.sv
// bf_pair_sched: pairs vector k of each block's first half with vector k of
// its second half and presents them, registered, to the butterfly ALU.
//   clk, rstn                 : clock, async active-low reset
//   clear                     : sync abort of the current block (wins over in_valid)
//   in_valid, data_in_*       : incoming vector, no backpressure
//   out_valid                 : registered pair present this cycle
//   out_a_* / out_b_*         : stored (earlier) / incoming (later) vector
//   pair_idx                  : position k of the pair within the block
//   block_done                : pulses with the last pair of a block
//   phase                     : 0 = FILL, 1 = PAIR
module bf_pair_sched
    import fft_pkg::*;
#(
    parameter  int WIDTH        = CPLX_W,
    parameter  int DELAY_LENGTH = 16,
    localparam int CW           = cnt_w(DELAY_LENGTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] data_in_real [0:LANES-1],
    input  logic signed [WIDTH-1:0] data_in_imag [0:LANES-1],
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_a_real   [0:LANES-1],
    output logic signed [WIDTH-1:0] out_a_imag   [0:LANES-1],
    output logic signed [WIDTH-1:0] out_b_real   [0:LANES-1],
    output logic signed [WIDTH-1:0] out_b_imag   [0:LANES-1],
    output logic [CW-1:0]           pair_idx,
    output logic                    block_done,
    output logic                    phase
);

    typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

    lanes_t din_re, din_im, rd_re, rd_im;

    pair_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          st_we;
    logic          last;

    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic [CW-1:0] idx_q, idx_d;
    lanes_t        a_re_q, a_re_d, a_im_q, a_im_d;
    lanes_t        b_re_q, b_re_d, b_im_q, b_im_d;

    // Unpacked port lanes <-> packed internal words.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign din_re[l]     = data_in_real[l];
        assign din_im[l]     = data_in_imag[l];
        assign out_a_real[l] = a_re_q[l];
        assign out_a_imag[l] = a_im_q[l];
        assign out_b_real[l] = b_re_q[l];
        assign out_b_imag[l] = b_im_q[l];
    end

    // Same counter addresses the write in FILL and the read in PAIR, so the
    // k-th PAIR beat always meets the k-th FILL beat regardless of gaps.
    bf_vec_store #(
        .WIDTH (WIDTH),
        .DEPTH (DELAY_LENGTH),
        .AW    (CW)
    ) u_store (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (st_we),
        .waddr_i (cnt_q),
        .wre_i   (din_re),
        .wim_i   (din_im),
        .raddr_i (cnt_q),
        .rre_o   (rd_re),
        .rim_o   (rd_im)
    );

    assign last = (cnt_q == CW'(DELAY_LENGTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_we   = 1'b0;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        idx_d   = '0;
        a_re_d  = '0;
        a_im_d  = '0;
        b_re_d  = '0;
        b_im_d  = '0;

        if (clear) begin
            state_d = FILL;
            cnt_d   = '0;
        end else if (in_valid) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                FILL: begin
                    st_we = 1'b1;
                    if (last) state_d = PAIR;
                end
                PAIR: begin
                    vld_d  = 1'b1;
                    idx_d  = cnt_q;
                    a_re_d = rd_re;
                    a_im_d = rd_im;
                    b_re_d = din_re;
                    b_im_d = din_im;
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            a_re_q  <= a_re_d;
            a_im_q  <= a_im_d;
            b_re_q  <= b_re_d;
            b_im_q  <= b_im_d;
        end
    end

    assign out_valid  = vld_q;
    assign block_done = done_q;
    assign pair_idx   = idx_q;
    assign phase      = (state_q == PAIR);

endmodule
